iccm_fetch_master: RTL and testbench
====================================

Name: iccm_fetch_master

Overview:
- AXI4 read master feeding the core's instruction stream from the ICCM BRAM controller; sits directly upstream of the ICCM AXI slave port.
- Fetches sequentially from a PC in aligned INCR bursts and buffers words in a prefetch FIFO.
- Presents words to decode through a valid/ready interface.
- Handles branch redirects by flushing the FIFO and discarding in-flight beats.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- BURST_LEN, 4, beats per aligned burst; power of two, 1..16.
- FIFO_DEPTH, 8, prefetch entries; power of two, >= BURST_LEN.
- AXI_ID, 4'h1, constant arid.

Ports:
- s_aclk  in  1  clock.
- s_areset  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored and forced to 00.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decode accepts head.
- inst_data  out  32  instruction word.
- inst_pc  out  32  address of inst_data.
- inst_err  out  1  word returned with rresp != OKAY.
- m_axi_araddr  out  32  burst start address.
- m_axi_arburst  out  2  constant 2'b01 (INCR).
- m_axi_arid  out  4  constant AXI_ID.
- m_axi_arlen  out  8  beats-1.
- m_axi_arsize  out  3  constant 3'b010.
- m_axi_arvalid  out  1  address valid.
- m_axi_arready  in  1  address accepted.
- m_axi_rdata  in  32  read data.
- m_axi_rid  in  4  ignored.
- m_axi_rlast  in  1  last beat.
- m_axi_rresp  in  2  response.
- m_axi_rvalid  in  1  data valid.
- m_axi_rready  out  1  data accept.

Behaviour:
- Reset (async assert, sync deassert use):
  - state=IDLE, pc=RESET_PC, FIFO empty, halted=0.
  - arvalid=0, rready=0, inst_valid=0, inst_err=0.
  - araddr=0, arlen=0.
- States:
  - IDLE: if !halted and free slots (FIFO_DEPTH - count) >= beats, register araddr=pc and arlen=beats-1, then go to ADDR. arvalid is high the cycle after the decision.
  - beats = BURST_LEN - pc[log2(BURST_LEN*4)-1:2]. Every burst therefore ends on a BURST_LEN*4-byte boundary, and subsequent bursts are full and aligned. No burst crosses 4 KB.
  - ADDR: hold arvalid, araddr and arlen stable until arready. On handshake, pc += beats*4, then go to DATA.
  - DATA: rready=1; free space is guaranteed. Each rvalid&rready beat pushes {rdata, beat_pc, rresp!=0} into the FIFO, and beat_pc increments by 4. On an rlast beat, go to IDLE. If any beat in the burst had an error, set halted=1: no further bursts issue until a redirect.
  - DRAIN: rready=1; beats are discarded. On the rlast beat, go to IDLE.
- Redirect (a single-cycle pulse is sufficient):
  - FIFO cleared in the same cycle, so inst_valid=0 the next cycle. A pop in the same cycle is ignored.
  - pc=redirect_pc & ~3, halted=0.
  - IDLE: remain in IDLE; the new burst is evaluated next cycle, so arvalid rises 2 cycles after redirect.
  - ADDR: arvalid must remain asserted until arready (no AXI retraction). After the handshake, go to DRAIN; the pc increment is suppressed.
  - DATA: go to DRAIN. If the redirect coincides with the rlast beat, that beat is dropped and the state goes to IDLE.
  - A redirect during DRAIN updates pc only.
- FIFO behaviour:
  - Push and pop in the same cycle are both allowed.
  - inst_valid = !empty, registered FIFO storage.
  - First word available 1 cycle after its r handshake.
  - Free-slot check counts current occupancy; bursts never overflow.
- Ordering: one outstanding burst maximum; rid is not checked.
- Reset mid-burst: returns immediately to IDLE; the slave is reset on the same domain.

Optional Feature:
- Macro ICCM_FETCH_STATS_EN.
- When defined, adds outputs perf_bursts (32, count of AR handshakes) and perf_dropped (32, count of discarded beats in DRAIN or on a redirect-coincident beat). Both counters saturate at all-ones and reset to 0.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset deassert with RESET_PC=0, BURST_LEN=4, and the slave preloaded with word[i]=i+0x100 -> first AR is araddr=0x0, arlen=3. inst_valid then delivers pcs 0x0,0x4,0x8,0xC with data 0x100..0x103, followed by an AR at 0x10.
- inst_ready=0 with FIFO_DEPTH=8 -> exactly 2 bursts issue (8 words), then arvalid stays 0. Popping 3 words yields no new AR until 4 slots are free.
- redirect_pc=0x0000_0026 -> first AR has araddr=0x24, arlen=2 (beats 0x24,0x28,0x2C), and the next AR is at 0x30 with arlen=3.
- Redirect to 0x80 while beat 2 of a 4-beat burst is in flight -> the remaining beats are discarded (perf_dropped=2 with the feature enabled). The first inst_pc after the redirect is 0x80, and no stale word is ever presented.
- Redirect while arvalid=1 and arready is held low for 5 cycles -> arvalid and araddr remain stable until the handshake, then all 4 beats are drained and the next AR is at the redirect target.
- Slave returns rresp=2'b10 on beat 1 -> that word is delivered with inst_err=1, no further AR issues, and a subsequent redirect resumes fetch.

Source files
------------

// File: rtl/iccm_fetch_master_if.sv
// AXI4 read-channel bundle (AR + R) between the ICCM fetch master and the ICCM slave port.
interface iccm_fetch_master_if;
  logic [31:0] m_axi_araddr;
  logic [1:0]  m_axi_arburst;
  logic [3:0]  m_axi_arid;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [3:0]  m_axi_rid;
  logic        m_axi_rlast;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  modport master (
    output m_axi_araddr, m_axi_arburst, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arvalid,
    output m_axi_rready,
    input  m_axi_arready, m_axi_rdata, m_axi_rid, m_axi_rlast, m_axi_rresp, m_axi_rvalid
  );

  modport slave (
    input  m_axi_araddr, m_axi_arburst, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arvalid,
    input  m_axi_rready,
    output m_axi_arready, m_axi_rdata, m_axi_rid, m_axi_rlast, m_axi_rresp, m_axi_rvalid
  );
endinterface

// File: rtl/iccm_fetch_master.sv
// ICCM instruction fetch master: issues aligned AXI4 INCR read bursts from a sequential PC,
// buffers returned words in a prefetch FIFO and presents them to decode via valid/ready.
// Branch redirects flush the FIFO and discard beats of any burst already in flight.
// Optional macro ICCM_FETCH_STATS_EN adds saturating perf_bursts / perf_dropped counters.
module iccm_fetch_master #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [3:0]  AXI_ID     = 4'h1
) (
  input  logic                       s_aclk,
  input  logic                       s_areset,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst_data,
  output logic [31:0]                inst_pc,
  output logic                       inst_err,
  iccm_fetch_master_if.master        axi
`ifdef ICCM_FETCH_STATS_EN
  ,
  output logic [31:0]                perf_bursts,
  output logic [31:0]                perf_dropped
`endif
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] DepthC    = CntW'(FIFO_DEPTH);
  localparam logic [PtrW-1:0] LastPtr   = PtrW'(FIFO_DEPTH - 1);
  localparam logic [31:0]     BurstMask = 32'(BURST_LEN - 1);
  localparam logic [31:0]     BurstLenC = 32'(BURST_LEN);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDrain} state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        err;
  } entry_t;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic            halted_q, halted_d;
  logic [31:0]     araddr_q, araddr_d;
  logic [7:0]      arlen_q, arlen_d;
  logic            arvalid_q, arvalid_d;
  logic [31:0]     beat_pc_q, beat_pc_d;
  logic            burst_err_q, burst_err_d;
  logic            redir_pend_q, redir_pend_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  entry_t          mem_q [FIFO_DEPTH];

  logic            rready;
  logic            ar_hs;
  logic            r_hs;
  logic            beat_err;
  logic            push;
  logic            pop;
  logic            drop;
  logic [31:0]     offset32;
  logic [31:0]     beats32;
  logic [CntW-1:0] beats;
  logic [CntW-1:0] free_slots;
  entry_t          head;

  // Beats to the next BURST_LEN*4-byte boundary, so every later burst is full and aligned.
  always_comb begin
    offset32   = (pc_q >> 2) & BurstMask;
    beats32    = BurstLenC - offset32;
    beats      = beats32[CntW-1:0];
    free_slots = DepthC - count_q;
  end

  assign rready   = (state_q == StData) || (state_q == StDrain);
  assign ar_hs    = arvalid_q && axi.m_axi_arready;
  assign r_hs     = axi.m_axi_rvalid && rready;
  assign beat_err = (axi.m_axi_rresp != 2'b00);

  // Fetch FSM next state: burst issue, beat accept/discard, halt on error, redirect handling.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    halted_d     = halted_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arvalid_d    = arvalid_q;
    beat_pc_d    = beat_pc_q;
    burst_err_d  = burst_err_q;
    redir_pend_d = redir_pend_q;
    push         = 1'b0;
    drop         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!redirect_valid && !halted_q && (free_slots >= beats)) begin
          araddr_d  = pc_q;
          arlen_d   = 8'(beats32 - 32'd1);
          arvalid_d = 1'b1;
          state_d   = StAddr;
        end
      end
      StAddr: begin
        // A redirect here cannot retract arvalid; remember it and drain the burst instead.
        redir_pend_d = redir_pend_q || redirect_valid;
        if (ar_hs) begin
          arvalid_d    = 1'b0;
          beat_pc_d    = araddr_q;
          burst_err_d  = 1'b0;
          redir_pend_d = 1'b0;
          if (redirect_valid || redir_pend_q) begin
            state_d = StDrain;
          end else begin
            state_d = StData;
            pc_d    = pc_q + ((32'(arlen_q) + 32'd1) << 2);
          end
        end
      end
      StData: begin
        if (r_hs) begin
          if (redirect_valid) begin
            drop    = 1'b1;
            state_d = axi.m_axi_rlast ? StIdle : StDrain;
          end else begin
            push        = 1'b1;
            beat_pc_d   = beat_pc_q + 32'd4;
            burst_err_d = burst_err_q || beat_err;
            if (axi.m_axi_rlast) begin
              state_d  = StIdle;
              halted_d = burst_err_q || beat_err;
            end
          end
        end else if (redirect_valid) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (r_hs) begin
          drop = 1'b1;
          if (axi.m_axi_rlast) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      halted_d = 1'b0;
    end
  end

  // FIFO pointers and occupancy; a redirect empties it and overrides any same-cycle pop.
  always_comb begin
    pop      = inst_valid && inst_ready && !redirect_valid;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      halted_q     <= 1'b0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arvalid_q    <= 1'b0;
      beat_pc_q    <= '0;
      burst_err_q  <= 1'b0;
      redir_pend_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      halted_q     <= halted_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arvalid_q    <= arvalid_d;
      beat_pc_q    <= beat_pc_d;
      burst_err_q  <= burst_err_d;
      redir_pend_q <= redir_pend_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // FIFO storage; contents are only meaningful below count_q, so no reset is needed.
  always_ff @(posedge s_aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{data: axi.m_axi_rdata, pc: beat_pc_q, err: beat_err};
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign inst_valid = (count_q != '0);
  assign inst_data  = head.data;
  assign inst_pc    = head.pc;
  assign inst_err   = inst_valid && head.err;

  assign axi.m_axi_araddr  = araddr_q;
  assign axi.m_axi_arburst = 2'b01;
  assign axi.m_axi_arid    = AXI_ID;
  assign axi.m_axi_arlen   = arlen_q;
  assign axi.m_axi_arsize  = 3'b010;
  assign axi.m_axi_arvalid = arvalid_q;
  assign axi.m_axi_rready  = rready;

  // rid is not checked (single outstanding burst) and the pc low bits are forced to zero.
  logic unused_bits;
  assign unused_bits = ^{axi.m_axi_rid, redirect_pc[1:0], beats32[31:CntW]};

`ifdef ICCM_FETCH_STATS_EN
  logic [31:0] perf_bursts_q, perf_bursts_d;
  logic [31:0] perf_dropped_q, perf_dropped_d;

  // Saturating event counters.
  always_comb begin
    perf_bursts_d  = perf_bursts_q;
    perf_dropped_d = perf_dropped_q;
    if (ar_hs && (perf_bursts_q != '1)) begin
      perf_bursts_d = perf_bursts_q + 32'd1;
    end
    if (drop && (perf_dropped_q != '1)) begin
      perf_dropped_d = perf_dropped_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      perf_bursts_q  <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_bursts_q  <= perf_bursts_d;
      perf_dropped_q <= perf_dropped_d;
    end
  end

  assign perf_bursts  = perf_bursts_q;
  assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_iccm_fetch_master.sv
// Self-checking bench for iccm_fetch_master with a behavioural ICCM AXI read slave
// returning word[i] = i + 0x100, plus a pop monitor tracking the expected instruction stream.
module tb_iccm_fetch_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_err;
`ifdef ICCM_FETCH_STATS_EN
  logic [31:0] perf_bursts;
  logic [31:0] perf_dropped;
`endif

  iccm_fetch_master_if axi ();

  iccm_fetch_master #(
    .RESET_PC   (32'h0000_0000),
    .BURST_LEN  (4),
    .FIFO_DEPTH (8),
    .AXI_ID     (4'h1)
  ) dut (
    .s_aclk         (clk),
    .s_areset       (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_err       (inst_err),
    .axi            (axi)
`ifdef ICCM_FETCH_STATS_EN
    ,
    .perf_bursts    (perf_bursts),
    .perf_dropped   (perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  int          errors;
  int          checks;
  int          ar_count;
  int          err_pops;
  logic [31:0] exp_pc;
  logic [31:0] err_pc;

  // Slave controls.
  logic        arready_en;
  int          err_beat;
  logic        s_busy;
  logic [31:0] s_addr;
  logic [7:0]  s_len;
  int          s_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ar(input string name);
    for (int i = 0; i < 100 && !axi.m_axi_arvalid; i++) tick();
    if (!axi.m_axi_arvalid) timeout(name);
  endtask

  task automatic wait_ar_done(input string name);
    for (int i = 0; i < 100 && axi.m_axi_arvalid; i++) tick();
    if (axi.m_axi_arvalid) timeout(name);
  endtask

  task automatic wait_idle(input string name);
    int quiet;
    quiet = 0;
    for (int i = 0; i < 200 && quiet < 4; i++) begin
      tick();
      if (!axi.m_axi_arvalid && !axi.m_axi_rready) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) timeout(name);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    exp_pc         = target & ~32'h3;
    tick();
    redirect_valid = 1'b0;
  endtask

  // Behavioural AXI read slave: one burst at a time, one beat per cycle.
  assign axi.m_axi_arready = arready_en && !s_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_busy           <= 1'b0;
      s_addr           <= '0;
      s_len            <= '0;
      s_idx            <= 0;
      axi.m_axi_rvalid <= 1'b0;
      axi.m_axi_rlast  <= 1'b0;
      axi.m_axi_rdata  <= '0;
      axi.m_axi_rresp  <= 2'b00;
      axi.m_axi_rid    <= 4'h0;
    end else if (!s_busy) begin
      if (axi.m_axi_arvalid && axi.m_axi_arready) begin
        s_busy           <= 1'b1;
        s_addr           <= axi.m_axi_araddr + 32'd4;
        s_len            <= axi.m_axi_arlen;
        s_idx            <= 1;
        axi.m_axi_rvalid <= 1'b1;
        axi.m_axi_rdata  <= (axi.m_axi_araddr >> 2) + 32'h100;
        axi.m_axi_rlast  <= (axi.m_axi_arlen == 8'd0);
        axi.m_axi_rresp  <= (err_beat == 0) ? 2'b10 : 2'b00;
        axi.m_axi_rid    <= axi.m_axi_arid;
      end
    end else if (axi.m_axi_rvalid && axi.m_axi_rready) begin
      if (axi.m_axi_rlast) begin
        s_busy           <= 1'b0;
        axi.m_axi_rvalid <= 1'b0;
        axi.m_axi_rlast  <= 1'b0;
        axi.m_axi_rresp  <= 2'b00;
      end else begin
        axi.m_axi_rdata <= (s_addr >> 2) + 32'h100;
        axi.m_axi_rlast <= (32'(s_len) == s_idx);
        axi.m_axi_rresp <= (s_idx == err_beat) ? 2'b10 : 2'b00;
        s_addr          <= s_addr + 32'd4;
        s_idx           <= s_idx + 1;
      end
    end
  end

  // Pop monitor: every word taken by decode must be the next sequential word of the stream.
  always @(negedge clk) begin
    if (!rst) begin
      if (axi.m_axi_arvalid && axi.m_axi_arready) ar_count++;
      if (inst_valid && inst_ready && !redirect_valid) begin
        check("pop_pc", inst_pc, exp_pc);
        check("pop_data", inst_data, (exp_pc >> 2) + 32'h100);
        check("pop_err", {31'b0, inst_err}, {31'b0, exp_pc == err_pc});
        if (inst_err) err_pops++;
        exp_pc = exp_pc + 32'd4;
      end
    end
  end

  typedef struct {
    logic [31:0] target;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] next;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          c0;
    logic [31:0] hold_addr;
    logic        seen;
`ifdef ICCM_FETCH_STATS_EN
    logic [31:0] drop0;
`endif
    errors = 0; checks = 0; ar_count = 0; err_pops = 0;
    exp_pc = 32'h0; err_pc = 32'hFFFF_FFFF;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    arready_en = 1'b1; err_beat = -1;

    vecs[0] = '{target: 32'h0000_0026, addr: 32'h24,  len: 8'd2, next: 32'h30};
    vecs[1] = '{target: 32'h0000_0080, addr: 32'h80,  len: 8'd3, next: 32'h90};
    vecs[2] = '{target: 32'h0000_003C, addr: 32'h3C,  len: 8'd0, next: 32'h40};
    vecs[3] = '{target: 32'h0000_0033, addr: 32'h30,  len: 8'd3, next: 32'h40};
    vecs[4] = '{target: 32'h0000_0109, addr: 32'h108, len: 8'd1, next: 32'h110};

    repeat (3) tick();
    check("rst_arvalid", {31'b0, axi.m_axi_arvalid}, 32'd0);
    check("rst_rready", {31'b0, axi.m_axi_rready}, 32'd0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst_err", {31'b0, inst_err}, 32'd0);
    check("rst_araddr", axi.m_axi_araddr, 32'd0);
    check("rst_arlen", {24'b0, axi.m_axi_arlen}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // First bursts after reset, decode stalled: two bursts fill the FIFO, then fetch stops.
    wait_ar("first_ar");
    check("first_araddr", axi.m_axi_araddr, 32'h0);
    check("first_arlen", {24'b0, axi.m_axi_arlen}, 32'd3);
    check("arburst", {30'b0, axi.m_axi_arburst}, 32'd1);
    check("arid", {28'b0, axi.m_axi_arid}, 32'd1);
    check("arsize", {29'b0, axi.m_axi_arsize}, 32'd2);
    wait_ar_done("first_ar_done");
    wait_ar("second_ar");
    check("second_araddr", axi.m_axi_araddr, 32'h10);
    check("second_arlen", {24'b0, axi.m_axi_arlen}, 32'd3);
    wait_idle("fill_idle");
    check("fill_ar_count", 32'(ar_count), 32'd2);
    check("fill_inst_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    repeat (3) tick();
    inst_ready = 1'b0;
    repeat (10) tick();
    check("pop3_ar_count", 32'(ar_count), 32'd2);
    check("pop3_arvalid", {31'b0, axi.m_axi_arvalid}, 32'd0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    wait_ar("pop4_ar");
    check("pop4_araddr", axi.m_axi_araddr, 32'h20);
    wait_idle("pop4_idle");

    // Redirect table, decode stalled so the fetcher is idle with a full FIFO beforehand.
    for (int v = 0; v < 5; v++) begin
      do_redirect(vecs[v].target);
      check("redir_flush_valid", {31'b0, inst_valid}, 32'd0);
      check("redir_arvalid_lat1", {31'b0, axi.m_axi_arvalid}, 32'd0);
      tick();
      check("redir_arvalid_lat2", {31'b0, axi.m_axi_arvalid}, 32'd1);
      check("redir_araddr", axi.m_axi_araddr, vecs[v].addr);
      check("redir_arlen", {24'b0, axi.m_axi_arlen}, {24'b0, vecs[v].len});
      wait_ar_done("redir_ar_done");
      wait_ar("redir_next_ar");
      check("redir_next_araddr", axi.m_axi_araddr, vecs[v].next);
      check("redir_next_arlen", {24'b0, axi.m_axi_arlen}, 32'd3);
      check("redir_head_valid", {31'b0, inst_valid}, 32'd1);
      check("redir_head_pc", inst_pc, vecs[v].addr);
      check("redir_head_data", inst_data, (vecs[v].addr >> 2) + 32'h100);
      wait_idle("redir_idle");
    end

    // Redirect coincident with beat 2 of a full burst while decode streams.
    inst_ready = 1'b1;
    wait_ar_done("mid_pre_done");
    wait_ar("mid_ar");
`ifdef ICCM_FETCH_STATS_EN
    drop0 = perf_dropped;
`endif
    repeat (3) tick();
    do_redirect(32'h80);
    check("mid_flush_valid", {31'b0, inst_valid}, 32'd0);
    wait_ar("mid_new_ar");
    check("mid_new_araddr", axi.m_axi_araddr, 32'h80);
    check("mid_new_arlen", {24'b0, axi.m_axi_arlen}, 32'd3);
`ifdef ICCM_FETCH_STATS_EN
    check("mid_dropped", perf_dropped - drop0, 32'd2);
`endif
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      seen = inst_valid;
    end
    if (!seen) timeout("mid_first_word");
    else check("mid_first_pc", inst_pc, 32'h80);

    // Redirect while the address phase is stalled by the slave.
    arready_en = 1'b0;
    wait_ar_done("stall_pre_done");
    wait_ar("stall_ar");
    tick();
    hold_addr = axi.m_axi_araddr;
    c0 = ar_count;
    do_redirect(32'h200);
    for (int i = 0; i < 5; i++) begin
      check("stall_arvalid", {31'b0, axi.m_axi_arvalid}, 32'd1);
      check("stall_araddr", axi.m_axi_araddr, hold_addr);
      tick();
    end
    arready_en = 1'b1;
    wait_ar_done("stall_done");
    wait_ar("stall_new_ar");
    check("stall_new_araddr", axi.m_axi_araddr, 32'h200);
    check("stall_new_arlen", {24'b0, axi.m_axi_arlen}, 32'd3);
    check("stall_ar_count", 32'(ar_count - c0), 32'd1);
    check("stall_drained_empty", {31'b0, inst_valid}, 32'd0);

    // Error response on beat 1 halts fetch until the next redirect.
    err_beat = 1;
    err_pc   = 32'h304;
    do_redirect(32'h300);
    wait_ar("err_ar");
    check("err_araddr", axi.m_axi_araddr, 32'h300);
    c0 = ar_count;
    wait_ar_done("err_ar_done");
    repeat (30) tick();
    check("err_halt_ar_count", 32'(ar_count - c0), 32'd1);
    check("err_halt_arvalid", {31'b0, axi.m_axi_arvalid}, 32'd0);
    check("err_pops", 32'(err_pops), 32'd1);
    check("err_drained_pc", exp_pc, 32'h310);
    err_beat = -1;
    do_redirect(32'h400);
    tick();
    check("resume_arvalid", {31'b0, axi.m_axi_arvalid}, 32'd1);
    check("resume_araddr", axi.m_axi_araddr, 32'h400);
    repeat (40) tick();
    inst_ready = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
